mux32_rr_arbiter: RTL and testbench
===================================

Name: mux32_rr_arbiter

Overview:
Round-robin arbiter that shares one mux32 between 32 requesters. It registers a 5-bit select that drives the mux32 select input, plus a one-hot grant vector. Each grant is held until the owner drops its request or a hold timeout expires. Ownership then moves to the next requester in circular order, so no requester starves.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may own the mux; 0 means unlimited
CNT_W, 8, width of the hold counter; must satisfy MAX_HOLD <= 2**CNT_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
req  input  32  request lines; req[i] = requester i wants the mux
select  output  5  registered index of the current owner; drives mux32 select
grant  output  32  registered one-hot grant; all zeros when no owner
grant_valid  output  1  high while some requester owns the mux
lock  input  1  exists only when ARB_LOCK_EN is defined (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low, including mid-grant: state=IDLE, select=0, grant=0, grant_valid=0, ptr=0, hold_cnt=0.
- Internal state:
  - ptr (5b): index where the next search starts.
  - hold_cnt (CNT_W bits).
  - State machine with states IDLE and GRANT.
- Search function pick(start): returns the first i with req[i]=1, scanning start, start+1, … 31, 0, … start-1 (mod 32). Index 31 wraps to 0.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise, on the next edge: idx=pick(ptr), select=idx, grant=1<<idx, grant_valid=1, hold_cnt=0, go to GRANT.
  - Latency from req assertion to grant_valid is 1 cycle.
- GRANT:
  - hold_cnt increments every cycle.
  - Only req[select] matters; changes on other req lines are ignored until release.
- Release condition (evaluated each GRANT cycle): req[select]==0, OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1). A grant therefore lasts at most MAX_HOLD cycles.
- On release, on the same edge:
  - ptr = select+1 (mod 32).
  - If req is nonzero, with req[select] included only if it is still high, re-grant pick(select+1) back-to-back with no idle bubble, and set hold_cnt=0.
  - Otherwise go to IDLE: grant=0, grant_valid=0, select keeps its last value.
- Timeout with a single requester: pick wraps back to the same index. That requester is re-granted, grant_valid stays 1, and hold_cnt restarts.
- Simultaneous requests: lowest index at or after ptr (circular) wins.
- MAX_HOLD=1: the grant rotates every cycle among the active requesters.
- Invariants: grant is always zero or one-hot, grant==(grant_valid<<select), and outputs never glitch because they are all registered.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined: the lock input is present. While grant_valid=1 and lock=1, the timeout term of the release condition is suppressed and hold_cnt saturates, so the owner keeps the mux until req[select] drops. When lock deasserts, the timeout resumes from the current hold_cnt and releases on the next edge if hold_cnt >= MAX_HOLD-1.
- Undefined: the lock port is absent and the timeout always applies.

Test Plan:
- Reset, then req=0 for 5 cycles -> grant_valid=0, grant=0, select=0 throughout; assert rst_n low mid-grant -> all outputs 0 immediately, no clock edge needed.
- req=32'h0000_0010 for 3 cycles, then 0 -> grant_valid rises 1 cycle after req; select=4, grant=32'h10 for 3 cycles, then IDLE; the next single request from 2 gives select=2, found by wrapping from ptr=5.
- req=32'h8000_0003 held, MAX_HOLD=8 -> grants rotate 0,1,31,0,…, each lasting exactly 8 cycles, with no idle cycle between owners.
- req=32'h0000_0001 held with MAX_HOLD=4 -> grant_valid stays 1, select=0 continuously, hold_cnt restarts every 4 cycles; with MAX_HOLD=0, select=0 indefinitely.
- Owner 5 drops req while req[6] and req[3] are high -> next edge select=6 (not 3), ptr=6.
- ARB_LOCK_EN, MAX_HOLD=4, req=32'h3, lock=1 for 10 cycles -> owner 0 held 10+ cycles; drop lock -> grant moves to 1 on the next edge.

Source files
------------

// File: rtl/mux32_rr_arbiter_if.sv
// mux32_rr_arbiter_if: request/grant bundle between requesters and the mux32 arbiter.
// The lock line is present only when ARB_LOCK_EN is defined.
interface mux32_rr_arbiter_if;
  logic [31:0] req;
  logic [4:0]  select;
  logic [31:0] grant;
  logic        grant_valid;
`ifdef ARB_LOCK_EN
  logic        lock;
  modport master (output req, lock, input select, grant, grant_valid);
  modport slave  (input req, lock, output select, grant, grant_valid);
`else
  modport master (output req, input select, grant, grant_valid);
  modport slave  (input req, output select, grant, grant_valid);
`endif
endinterface

// File: rtl/mux32_rr_arbiter.sv
// mux32_rr_arbiter: round-robin owner of a shared mux32 with hold timeout, registered select/grant.
// Optional ARB_LOCK_EN adds a lock input that suppresses the timeout while asserted.
module mux32_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  mux32_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            state, state_n;
  logic [4:0]        select, select_n, ptr, ptr_n;
  logic [31:0]       grant;
  logic              grant_valid, grant_valid_n, timeout, rel;
  logic [CNT_W-1:0]  hold_cnt, hold_n;
  function automatic logic [4:0] pick(input logic [31:0] r, input logic [4:0] s);
    logic [4:0] idx;
    pick = s;
    for (int k = 31; k >= 0; k--) begin
      idx = s + 5'(k);
      if (r[idx]) pick = idx;
    end
  endfunction
  // The >= form lets a held-past-limit owner release right after lock drops.
`ifdef ARB_LOCK_EN
  assign timeout = MAX_HOLD != 0 && !bus.lock && hold_cnt >= CNT_W'(MAX_HOLD - 1);
`else
  assign timeout = MAX_HOLD != 0 && hold_cnt == CNT_W'(MAX_HOLD - 1);
`endif
  assign rel = !bus.req[select] || timeout;
  always_comb begin
    state_n       = state;
    select_n      = select;
    grant_valid_n = grant_valid;
    ptr_n         = ptr;
    hold_n        = hold_cnt;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n       = GRANT;
        select_n      = pick(bus.req, ptr);
        grant_valid_n = 1'b1;
        hold_n        = '0;
      end
    end else if (rel) begin
      ptr_n         = select + 5'd1;
      state_n       = |bus.req ? GRANT : IDLE;
      grant_valid_n = |bus.req;
      select_n      = |bus.req ? pick(bus.req, select + 5'd1) : select;
      hold_n        = '0;
    end else begin
      hold_n = hold_cnt + CNT_W'(hold_cnt != '1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      select      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      select      <= select_n;
      grant       <= grant_valid_n ? 32'd1 << select_n : '0;
      grant_valid <= grant_valid_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
    end
  end
  assign bus.select      = select;
  assign bus.grant       = grant;
  assign bus.grant_valid = grant_valid;
endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// tb_mux32_rr_arbiter: four arbiters (MAX_HOLD 8,4,0,1) share one req bus and are checked
// against an owner/held-cycles reference model; lock scenario only under ARB_LOCK_EN.
module tb_mux32_rr_arbiter;
  logic clk = 0, rst_n = 0;
  logic [31:0] req = '0;
`ifdef ARB_LOCK_EN
  logic lock = 0;
`endif
  logic [4:0]  o_sel[4];
  logic [31:0] o_gnt[4];
  logic        o_gv[4];
  int mh[4] = '{8, 4, 0, 1};
  int m_own[4], m_held[4], m_ptr[4], m_last[4];
  logic [4:0]  e_sel[4];
  logic [31:0] e_gnt[4];
  logic        e_gv[4];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  generate
    for (genvar g = 0; g < 4; g++) begin : inst
      mux32_rr_arbiter_if b();
      assign b.req = req;
`ifdef ARB_LOCK_EN
      assign b.lock = lock;
`endif
      assign o_sel[g] = b.select;
      assign o_gnt[g] = b.grant;
      assign o_gv[g]  = b.grant_valid;
      mux32_rr_arbiter #(.MAX_HOLD(g == 0 ? 8 : g == 1 ? 4 : g == 2 ? 0 : 1), .CNT_W(8))
        dut (.clk(clk), .rst_n(rst_n), .bus(b));
    end
  endgenerate
  function automatic int first(input logic [31:0] r, input int s);
    for (int k = 0; k < 32; k++) if (r[(s + k) % 32]) return (s + k) % 32;
    return -1;
  endfunction
  task automatic refresh();
    for (int d = 0; d < 4; d++) begin
      e_gv[d]  = m_own[d] >= 0;
      e_sel[d] = 5'(m_own[d] >= 0 ? m_own[d] : m_last[d]);
      e_gnt[d] = e_gv[d] ? 32'd1 << e_sel[d] : '0;
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_own[d] = -1; m_held[d] = 0; m_ptr[d] = 0; m_last[d] = 0;
    end
    refresh();
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  // Drive req, take one edge, advance the model with what the DUTs sampled.
  task automatic step(input logic [31:0] r);
    bit lk;
    req = r;
    @(posedge clk);
`ifdef ARB_LOCK_EN
    lk = lock;
`else
    lk = 0;
`endif
    for (int d = 0; d < 4; d++) begin
      if (m_own[d] < 0) begin
        if (r != 0) begin m_own[d] = first(r, m_ptr[d]); m_held[d] = 1; end
      end else if (!r[m_own[d]] || (mh[d] != 0 && !lk && m_held[d] >= mh[d])) begin
        m_ptr[d]  = (m_own[d] + 1) % 32;
        m_last[d] = m_own[d];
        if (r != 0) begin m_own[d] = first(r, m_ptr[d]); m_held[d] = 1; end
        else m_own[d] = -1;
      end else m_held[d]++;
    end
    refresh();
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    repeat (5) begin
      step('0);
      for (int d = 0; d < 4; d++) begin
        total++;
        if (o_gv[d] !== 1'b0 || o_sel[d] !== 5'd0 || o_gnt[d] !== 32'd0)
          $display("FAIL idle_after_reset d=%0d got gv=%b sel=%0d gnt=%h want 0/0/0", d, o_gv[d], o_sel[d], o_gnt[d]);
        else passed++;
      end
    end
    step(32'h100);
    step(32'h100);
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({o_gv[d], o_sel[d], o_gnt[d]} !== {e_gv[d], e_sel[d], e_gnt[d]})
        $display("FAIL pre_reset_grant d=%0d got gv=%b sel=%0d gnt=%h want gv=%b sel=%0d gnt=%h", d, o_gv[d], o_sel[d], o_gnt[d], e_gv[d], e_sel[d], e_gnt[d]);
      else passed++;
    end
    rst_n = 0;
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (o_gv[d] !== 1'b0 || o_sel[d] !== 5'd0 || o_gnt[d] !== 32'd0)
        $display("FAIL async_reset d=%0d got gv=%b sel=%0d gnt=%h want 0/0/0", d, o_gv[d], o_sel[d], o_gnt[d]);
      else passed++;
    end
    model_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_single_and_wrap();
    logic [31:0] pat[7] = '{32'h10, 32'h10, 32'h10, 32'h0, 32'h0, 32'h4, 32'h0};
    for (int i = 0; i < 7; i++) begin
      step(pat[i]);
      for (int d = 0; d < 4; d++) begin
        total++;
        if ({o_gv[d], o_sel[d], o_gnt[d]} !== {e_gv[d], e_sel[d], e_gnt[d]})
          $display("FAIL single_wrap i=%0d d=%0d got gv=%b sel=%0d gnt=%h want gv=%b sel=%0d gnt=%h", i, d, o_gv[d], o_sel[d], o_gnt[d], e_gv[d], e_sel[d], e_gnt[d]);
        else passed++;
      end
      if (i == 0 || i == 5) begin
        total++;
        if (o_gv[0] !== 1'b1 || o_sel[0] !== (i == 0 ? 5'd4 : 5'd2))
          $display("FAIL single_select i=%0d got gv=%b sel=%0d want gv=1 sel=%0d", i, o_gv[0], o_sel[0], i == 0 ? 4 : 2);
        else passed++;
      end
    end
  endtask
  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(32'h8000_0003);
      for (int d = 0; d < 4; d++) begin
        total++;
        if ({o_gv[d], o_sel[d], o_gnt[d]} !== {e_gv[d], e_sel[d], e_gnt[d]} || o_gv[d] !== 1'b1)
          $display("FAIL rotation i=%0d d=%0d got gv=%b sel=%0d gnt=%h want gv=%b sel=%0d gnt=%h", i, d, o_gv[d], o_sel[d], o_gnt[d], e_gv[d], e_sel[d], e_gnt[d]);
        else passed++;
      end
    end
    step('0);
  endtask
  task automatic test_hold_single();
    for (int i = 0; i < 20; i++) begin
      step(32'h1);
      for (int d = 0; d < 4; d++) begin
        total++;
        if (o_gv[d] !== 1'b1 || o_sel[d] !== 5'd0 || o_gnt[d] !== 32'h1 || o_sel[d] !== e_sel[d])
          $display("FAIL hold_single i=%0d d=%0d got gv=%b sel=%0d gnt=%h want gv=1 sel=0 gnt=1", i, d, o_gv[d], o_sel[d], o_gnt[d]);
        else passed++;
      end
    end
    step('0);
  endtask
  task automatic test_drop_priority();
    logic [31:0] pat[3] = '{32'h20, 32'h68, 32'h48};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(pat[i]);
      for (int d = 0; d < 4; d++) begin
        total++;
        if ({o_gv[d], o_sel[d], o_gnt[d]} !== {e_gv[d], e_sel[d], e_gnt[d]})
          $display("FAIL drop_priority i=%0d d=%0d got gv=%b sel=%0d gnt=%h want gv=%b sel=%0d gnt=%h", i, d, o_gv[d], o_sel[d], o_gnt[d], e_gv[d], e_sel[d], e_gnt[d]);
        else passed++;
      end
    end
    total++;
    if (o_sel[0] !== 5'd6 || o_gnt[0] !== 32'h40)
      $display("FAIL drop_next_owner got sel=%0d gnt=%h want sel=6 gnt=40", o_sel[0], o_gnt[0]);
    else passed++;
    step('0);
  endtask
`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 1;
    for (int i = 0; i < 12; i++) begin
      step(32'h3);
      total++;
      if (o_sel[1] !== 5'd0 || o_gv[1] !== 1'b1 || o_sel[1] !== e_sel[1])
        $display("FAIL lock_hold i=%0d got gv=%b sel=%0d want gv=1 sel=0", i, o_gv[1], o_sel[1]);
      else passed++;
    end
    lock = 0;
    step(32'h3);
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({o_gv[d], o_sel[d], o_gnt[d]} !== {e_gv[d], e_sel[d], e_gnt[d]})
        $display("FAIL lock_release d=%0d got gv=%b sel=%0d gnt=%h want gv=%b sel=%0d gnt=%h", d, o_gv[d], o_sel[d], o_gnt[d], e_gv[d], e_sel[d], e_gnt[d]);
      else passed++;
    end
    total++;
    if (o_sel[1] !== 5'd1)
      $display("FAIL lock_release_owner got sel=%0d want 1", o_sel[1]);
    else passed++;
    step('0);
  endtask
`endif
  task automatic test_random();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 5) == 0 ? 32'h0 : $urandom & $urandom & $urandom;
`ifdef ARB_LOCK_EN
      lock = $urandom_range(0, 3) == 0;
`endif
      repeat ($urandom_range(1, 6)) begin
        step(r);
        for (int d = 0; d < 4; d++) begin
          total++;
          if ({o_gv[d], o_sel[d], o_gnt[d]} !== {e_gv[d], e_sel[d], e_gnt[d]})
            $display("FAIL random i=%0d d=%0d req=%h got gv=%b sel=%0d gnt=%h want gv=%b sel=%0d gnt=%h", i, d, r, o_gv[d], o_sel[d], o_gnt[d], e_gv[d], e_sel[d], e_gnt[d]);
          else passed++;
        end
      end
    end
`ifdef ARB_LOCK_EN
    lock = 0;
`endif
  endtask
  initial begin
    model_reset();
    test_reset();
    test_single_and_wrap();
    test_rotation();
    test_hold_single();
    test_drop_priority();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
